ibex_mem_arbiter: RTL

// Shares a single external memory port between the core's instruction and data request interfaces.

---
 rtl/ibex_mem_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ibex_mem_arbiter.sv
// Two-host (instr/data) arbiter onto one req/gnt/rvalid memory port.
// Forwards the winner's payload and keeps a FIFO of granted host IDs
// so in-order responses are steered back to whichever host issued them.
module ibex_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          RoundRobin     = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                    state_q, state_d;
  logic                      lock_id_q, lock_id_d;   // host frozen while LOCKED (1=data)
  logic                      last_q, last_d;         // last granted host (1=data)
  logic [MaxOutstanding-1:0] id_mem_q, id_mem_d;
  logic [PtrW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]           count_q, count_d;

  logic win_id, win_req, grant, pop, fifo_empty, head_id;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(MaxOutstanding - 1)) return '0;
    return p + PtrW'(1);
  endfunction

  // Winner selection: frozen while LOCKED, otherwise lone requester or tie-break.
  always_comb begin
    win_id = 1'b0;
    if (state_q == LOCKED)                 win_id = lock_id_q;
    else if (instr_req_i && data_req_i)    win_id = RoundRobin ? ~last_q : 1'b1;
    else                                   win_id = data_req_i;
  end

  assign win_req    = win_id ? data_req_i : instr_req_i;
  // Uses the registered count only: a full FIFO blocks even if a response pops this cycle.
  assign mem_req_o  = win_req & (count_q < CntW'(MaxOutstanding));
  assign grant      = mem_req_o & mem_gnt_i;
  assign fifo_empty = (count_q == '0);
  assign pop        = mem_rvalid_i & ~fifo_empty;
  assign head_id    = id_mem_q[rptr_q];

  // Lock state register plus bookkeeping flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      lock_id_q <= 1'b0;
      last_q    <= 1'b1;
      id_mem_q  <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      last_q    <= last_d;
      id_mem_q  <= id_mem_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
    end
  end

  // Next lock state: hold the winner while the memory stalls a request.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    case (state_q)
      IDLE: begin
        if (mem_req_o && !mem_gnt_i) begin
          state_d   = LOCKED;
          lock_id_d = win_id;
        end
      end
      LOCKED: begin
        // A withdrawn request releases the lock; arbitration restarts next cycle.
        if (mem_gnt_i || !win_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grants, downstream payload and response steering.
  always_comb begin
    instr_gnt_o    = grant & ~win_id;
    data_gnt_o     = grant &  win_id;
    instr_rvalid_o = pop & ~head_id;
    data_rvalid_o  = pop &  head_id;
    mem_we_o       = 1'b0;
    mem_be_o       = 4'h0;
    mem_addr_o     = 32'h0;
    mem_wdata_o    = 32'h0;
    if (mem_req_o) begin
      if (win_id) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = 4'hF;
        mem_addr_o  = instr_addr_i;
      end
    end
  end

  assign rsp_rdata_o = mem_rdata_i;
  assign rsp_err_o   = mem_err_i;

  // ID FIFO push/pop, occupancy and round-robin history.
  always_comb begin
    id_mem_d = id_mem_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (grant) begin
      id_mem_d[wptr_q] = win_id;
      wptr_d           = ptr_inc(wptr_q);
      last_d           = win_id;
    end
    if (pop) rptr_d = ptr_inc(rptr_q);
    case ({grant, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // A response with nothing outstanding is dropped; flag it as a bus protocol error.
  assert property (@(posedge clk_i) disable iff (rst_i) !(mem_rvalid_i && fifo_empty))
    else $warning("ibex_mem_arbiter: mem_rvalid_i with no outstanding request, dropped");

endmodule
